// File: rtl/cache_pkg.sv
// Shared types and width helpers for the cache refill path.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } refill_state_t;

  function automatic int beats_f(input int line_w, input int beat_w);
    return line_w / beat_w;
  endfunction

  function automatic int wen_width_f(input int line_w, input int byte_w);
    return line_w / byte_w;
  endfunction

endpackage

// File: rtl/cache_refill_buffer.sv
// Assembles a wrapped refill burst into one line and commits it to the data RAM in one write.
// Optional critical-word forwarding is built when REFILL_CRIT_FWD_EN is defined.
module cache_refill_buffer
  import cache_pkg::*;
#(
  parameter int dataWidth = 32,
  parameter int portWidth = 256,
  parameter int ramDepth  = 128,
  parameter int byteWidth = 8,
  localparam int BEATS    = beats_f(portWidth, dataWidth),
  localparam int wenWidth = wen_width_f(portWidth, byteWidth),
  localparam int idxWidth = $clog2(ramDepth),
  localparam int ptrWidth = $clog2(BEATS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [idxWidth-1:0]  req_index,
  input  logic [ptrWidth-1:0]  req_word,
  input  logic                 beat_valid,
  output logic                 beat_ready,
  input  logic [dataWidth-1:0] beat_data,
  input  logic                 beat_last,
  output logic                 fwd_valid,
  output logic [dataWidth-1:0] fwd_data,
  output logic                 ram_ena,
  output logic [idxWidth-1:0]  ram_addra,
  output logic [wenWidth-1:0]  ram_wen,
  output logic [portWidth-1:0] ram_wdata,
  output logic                 done,
  output logic                 err
);

  localparam logic [ptrWidth-1:0] LAST_CNT = ptrWidth'(BEATS - 1);

  refill_state_t        state_q, state_d;
  logic [idxWidth-1:0]  index_q, index_d;
  logic [ptrWidth-1:0]  ptr_q, ptr_d;
  logic [ptrWidth-1:0]  cnt_q, cnt_d;
  logic [portWidth-1:0] line_q, line_d;
  logic                 err_q, err_d;
  logic                 beat_fire;
  logic                 last_beat;

  assign beat_fire = (state_q == FILL) && beat_valid;
  assign last_beat = (cnt_q == LAST_CNT);

  // The beat count alone ends the fill; beat_last only feeds the sticky error.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          index_d = req_index;
          ptr_d   = req_word;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (beat_valid) begin
          line_d[ptr_q*dataWidth +: dataWidth] = beat_data;
          ptr_d = (ptr_q == LAST_CNT) ? '0 : ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (beat_last != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = WRITE;
          end
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      index_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign beat_ready = (state_q == FILL);
  assign ram_ena    = (state_q == WRITE);
  assign done       = ram_ena;
  assign ram_wen    = {wenWidth{ram_ena}};
  assign ram_addra  = ram_ena ? index_q : '0;
  assign ram_wdata  = ram_ena ? line_q : '0;
  assign err        = err_q;

`ifdef REFILL_CRIT_FWD_EN
  logic                 fwd_valid_q, fwd_valid_d;
  logic [dataWidth-1:0] fwd_data_q, fwd_data_d;

  // The first accepted beat of a refill is the critical word.
  always_comb begin
    fwd_valid_d = beat_fire && (cnt_q == '0);
    fwd_data_d  = fwd_valid_d ? beat_data : fwd_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_data  = fwd_data_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_data  = '0;
`endif

endmodule

// File: doc/cache_refill_buffer.md
# cache_refill_buffer

Collects the word-wide read-data beats of a cache-line refill burst from the bus interface and assembles them into one full line. It then commits the line to the cache data RAM (simpleDualPortRam, port A) in a single full-width write. It sits directly upstream of the data RAM write port and accepts the wrapped burst starting at the critical word. Optionally it forwards the critical word to the pipeline as soon as that word arrives.

## Interface
- `dataWidth`, 32, bus beat width in bits
- `portWidth`, 256, cache line / RAM port width in bits
- `ramDepth`, 128, number of lines in the data RAM
- `byteWidth`, 8, bits per RAM write-enable lane
- Derived (localparam): `BEATS = portWidth/dataWidth`, `wenWidth = portWidth/byteWidth`
- Reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  refill request
- `req_ready`  out  1  buffer idle, accepts request
- `req_index`  in  $clog2(ramDepth)  target line index
- `req_word`  in  $clog2(BEATS)  critical word offset (first beat's position)
- `beat_valid`  in  1  read-data beat valid
- `beat_ready`  out  1  beat accepted
- `beat_data`  in  dataWidth  beat payload
- `beat_last`  in  1  bus-signalled final beat
- `fwd_valid`  out  1  critical word forward strobe
- `fwd_data`  out  dataWidth  critical word
- `ram_ena`  out  1  RAM port A enable
- `ram_addra`  out  $clog2(ramDepth)  RAM write address
- `ram_wen`  out  wenWidth  RAM byte write enables
- `ram_wdata`  out  portWidth  assembled line
- `done`  out  1  one-cycle pulse: line committed
- `err`  out  1  sticky: `beat_last` mismatch on the last refill

## Operation
- FSM states:
  - IDLE: `req_ready=1`. On `req_valid`, latch `req_index`; load the word pointer `ptr=req_word` and beat count `cnt=0`; clear `err`; go to FILL.
  - FILL: `beat_ready=1`. Each accepted beat writes `line[ptr*dataWidth +: dataWidth]`.
    - `ptr` increments modulo BEATS (wraps BEATS-1 -> 0).
    - `cnt` increments.
    - When the beat with `cnt==BEATS-1` is accepted, go to WRITE.
  - WRITE: `ram_ena=1`, `ram_wen` all ones, `ram_addra=` latched index, `ram_wdata=line`, `done=1`; go to IDLE.
- `err` sets if `beat_last` is high while `cnt!=BEATS-1`, or low while `cnt==BEATS-1`. Completion is governed by the count alone; `beat_last` never shortens or extends the fill.
- `beat_valid` in IDLE or WRITE is not accepted (`beat_ready=0`).
- `req_valid` outside IDLE is ignored (`req_ready=0`).
- Reset mid-operation: go to IDLE immediately; the partial line is discarded; no RAM write occurs.

## Timing
- Reset values:
  - `req_ready=1`
  - `beat_ready=0`, `ram_ena=0`, `ram_wen=0`, `done=0`, `err=0`, `fwd_valid=0`
  - `ram_addra=0`, `ram_wdata=0`, `fwd_data=0`
- Request accepted at cycle T; FILL at T+1; beats are accepted in the same cycle they are valid, with no bubbles required.
- Last beat accepted at cycle N:
  - WRITE and `done` at N+1.
  - `req_ready` at N+2.
  - A RAM read of that index issued at N+2 returns the new line at N+3 (1-cycle read latency).
- Minimum request-to-request spacing: BEATS+2 cycles.
- The `ram_*` outputs are registered or decoded from state and are glitch-free in the cycle they are used.

## Configuration
- `REFILL_CRIT_FWD_EN` defined:
  - `fwd_valid` pulses for one cycle, the cycle after the first beat of each refill is accepted.
  - `fwd_data` holds that beat until the next refill's first beat.
- Undefined: `fwd_valid` and `fwd_data` are tied to 0, and the forward registers are not built.

## Structure
- Shared package `cache_pkg`:
  - `refill_state_t` enum (IDLE, FILL, WRITE)
  - `BEATS` / width helper functions
- Single module; no sub-module. The line register is a flat `portWidth` vector with indexed part-select writes.

## Test plan
- `req_word=0`, beats 0x11..0x88 back-to-back with `beat_last` on the 8th beat:
  - one RAM write at N+1 with `ram_wen=32'hFFFF_FFFF`, word0=0x11 … word7=0x88
  - `done` pulses once, `err=0`
- `req_word=5`, beats A..H: line words 5,6,7,0,1,2,3,4 = A..H (wrap check).
- `beat_valid` toggling every other cycle: the write still occurs exactly one cycle after the 8th accepted beat, with correct data.
- `beat_last` asserted on the 3rd beat: fill continues to 8 beats, the line is written, `err=1` until the next request.
- Reset asserted after 4 beats: no `ram_ena` pulse; all outputs return to reset values; the next full refill writes a correct line.
- With `REFILL_CRIT_FWD_EN`, `req_word=3`, first beat 0xDEAD_BEEF: `fwd_valid` is high for exactly one cycle after that beat, with `fwd_data=0xDEAD_BEEF`.
